// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU sequencer: state codes, opcode
// classes and the RV32 base opcodes the decoder recognises.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  // Flat constants for the FSM register, which stays plain logic [2:0].
  localparam logic [2:0] S_FETCH  = ST_FETCH;
  localparam logic [2:0] S_DECODE = ST_DECODE;
  localparam logic [2:0] S_EXEC   = ST_EXEC;
  localparam logic [2:0] S_MEM    = ST_MEM;
  localparam logic [2:0] S_WB     = ST_WB;
  localparam logic [2:0] S_TRAP   = ST_TRAP;

  typedef enum logic [2:0] {
    CL_ALU    = 3'd0,
    CL_LOAD   = 3'd1,
    CL_STORE  = 3'd2,
    CL_BRANCH = 3'd3,
    CL_JUMP   = 3'd4,
    CL_UPPER  = 3'd5,
    CL_NONE   = 3'd7
  } opclass_e;

  localparam logic [6:0] OP_ALU    = 7'b0110011;
  localparam logic [6:0] OP_ALUI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

endpackage

// File: rtl/cpu_opclass.sv
// Combinational opcode classifier; anything outside the known set is illegal.
module cpu_opclass
  import cpu_pkg::*;
(
  input  logic [6:0] opcode,
  output opclass_e   cls,
  output logic       illegal
);

  always_comb begin
    cls = CL_NONE;
    case (opcode)
      OP_ALU, OP_ALUI:   cls = CL_ALU;
      OP_LOAD:           cls = CL_LOAD;
      OP_STORE:          cls = CL_STORE;
      OP_BRANCH:         cls = CL_BRANCH;
      OP_JAL, OP_JALR:   cls = CL_JUMP;
      OP_LUI, OP_AUIPC:  cls = CL_UPPER;
      default:           cls = CL_NONE;
    endcase
    illegal = (cls == CL_NONE);
  end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle CPU control FSM: FETCH/DECODE/EXEC/MEM/WB with a sticky TRAP.
// Define CPU_SEQ_PERF_CNT_EN to build the cycle/instret performance counters.
module cpu_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  output logic        instr_req,
  input  logic        instr_ack,
  output logic        data_req,
  output logic        data_we,
  input  logic        data_ack,
  output logic        ir_en,
  output logic        pc_en,
  output logic        reg_we,
  output logic [2:0]  state_o,
  output logic        illegal,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);

  logic [2:0] state, nxt;
  opclass_e   dec_cls, cls_q;
  logic       dec_ill;

  cpu_opclass u_opclass (
    .opcode  (opcode),
    .cls     (dec_cls),
    .illegal (dec_ill)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      cls_q <= CL_NONE;
    end else begin
      state <= nxt;
      if (state == S_DECODE) cls_q <= dec_cls;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_FETCH:  if (instr_ack) nxt = S_DECODE;
      S_DECODE: nxt = dec_ill ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (cls_q)
          CL_LOAD, CL_STORE: nxt = S_MEM;
          CL_BRANCH:         nxt = S_FETCH;
          default:           nxt = S_WB;
        endcase
      end
      S_MEM:    if (data_ack) nxt = (cls_q == CL_STORE) ? S_FETCH : S_WB;
      S_WB:     nxt = S_FETCH;
      default:  nxt = S_TRAP;
    endcase
  end

  // Reset forces FETCH asynchronously, so instr_req alone needs rst_n gating.
  assign instr_req = rst_n && (state == S_FETCH);
  assign ir_en     = instr_req && instr_ack;
  assign data_req  = (state == S_MEM);
  assign data_we   = data_req && (cls_q == CL_STORE);
  assign reg_we    = (state == S_WB);
  assign pc_en     = ((state == S_EXEC) && (cls_q == CL_BRANCH))
                   || (data_req && (cls_q == CL_STORE) && data_ack)
                   || (state == S_WB);
  assign illegal   = (state == S_TRAP);
  assign state_o   = state;

`ifdef CPU_SEQ_PERF_CNT_EN
  logic [31:0] cyc_q, ret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else if (state != S_TRAP) begin
      cyc_q <= cyc_q + 32'd1;
      if (pc_en) ret_q <= ret_q + 32'd1;
    end
  end

  assign cycle_cnt   = cyc_q;
  assign instret_cnt = ret_q;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized scoreboard bench for cpu_sequencer: the driver pushes a per-
// instruction expectation, a negedge monitor pops and compares on retirement.
module tb_cpu_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = 7'd0;
  logic        instr_ack = 1'b0, data_ack = 1'b0;
  logic        instr_req, data_req, data_we, ir_en, pc_en, reg_we, illegal;
  logic [2:0]  state_o;
  logic [31:0] cycle_cnt, instret_cnt;

  always #5 clk = ~clk;

  cpu_sequencer dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .instr_req   (instr_req),
    .instr_ack   (instr_ack),
    .data_req    (data_req),
    .data_we     (data_we),
    .data_ack    (data_ack),
    .ir_en       (ir_en),
    .pc_en       (pc_en),
    .reg_we      (reg_we),
    .state_o     (state_o),
    .illegal     (illegal),
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
  );

  typedef struct {
    int          lat;
    logic [63:0] trace;
    int          rw, dr, dwe, ir;
  } exp_t;

  exp_t q[$];
  int   checks = 0, failures = 0;
  bit   mon_en = 1'b1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected per-instruction behaviour: 3-bit state per cycle, strobe counts.
  function automatic exp_t model(input logic [6:0] op, input int fw, input int dw);
    exp_t e;
    int kind; // 0 writeback class, 1 load, 2 store, 3 branch, 4 illegal
    case (op)
      7'b0110011, 7'b0010011, 7'b1101111,
      7'b1100111, 7'b0110111, 7'b0010111: kind = 0;
      7'b0000011: kind = 1;
      7'b0100011: kind = 2;
      7'b1100011: kind = 3;
      default:    kind = 4;
    endcase
    e.trace = '0; e.lat = 0;
    for (int i = 0; i <= fw; i++) begin e.trace = e.trace << 3; e.lat++; end
    e.trace = (e.trace << 3) | 64'd1; e.lat++;
    if (kind == 4) begin
      e.trace = (e.trace << 3) | 64'd5; e.lat++;
    end else begin
      e.trace = (e.trace << 3) | 64'd2; e.lat++;
      if (kind == 1 || kind == 2)
        for (int i = 0; i <= dw; i++) begin e.trace = (e.trace << 3) | 64'd3; e.lat++; end
      if (kind == 0 || kind == 1) begin e.trace = (e.trace << 3) | 64'd4; e.lat++; end
    end
    e.rw  = (kind == 0 || kind == 1) ? 1 : 0;
    e.dr  = (kind == 1 || kind == 2) ? dw + 1 : 0;
    e.dwe = (kind == 2) ? dw + 1 : 0;
    e.ir  = 1;
    return e;
  endfunction

  int          m_lat, m_rw, m_dr, m_dwe, m_ir;
  logic [63:0] m_tr;
  bit          trapped;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst_n || !mon_en) begin
      m_lat = 0; m_rw = 0; m_dr = 0; m_dwe = 0; m_ir = 0; m_tr = '0; trapped = 1'b0;
    end else begin
      m_lat++;
      m_tr = (m_tr << 3) | 64'(state_o);
      m_rw += int'(reg_we); m_dr += int'(data_req);
      m_dwe += int'(data_we); m_ir += int'(ir_en);
      if (pc_en || (illegal && !trapped)) begin
        if (q.size() == 0) chk("retire_without_issue", 64'(q.size()), 64'd1);
        else begin
          e = q.pop_front();
          chk("latency", 64'(m_lat), 64'(e.lat));
          chk("state_trace", m_tr, e.trace);
          chk("reg_we_cycles", 64'(m_rw), 64'(e.rw));
          chk("data_req_cycles", 64'(m_dr), 64'(e.dr));
          chk("data_we_cycles", 64'(m_dwe), 64'(e.dwe));
          chk("ir_en_cycles", 64'(m_ir), 64'(e.ir));
        end
        m_lat = 0; m_rw = 0; m_dr = 0; m_dwe = 0; m_ir = 0; m_tr = '0;
      end
      trapped = illegal;
    end
  end

  // Ack the selected req after w waited req cycles; the idle ack wiggles randomly.
  task automatic hs(input bit dph, input int w, input logic [6:0] op);
    int n = 0;
    bit done = 1'b0;
    bit r;
    for (int g = 0; g < 64 && !done; g++) begin
      r = dph ? data_req : instr_req;
      instr_ack = instr_req ? (!dph && n == w) : 1'($urandom_range(1));
      data_ack  = data_req  ? (dph && n == w)  : 1'($urandom_range(1));
      if (!dph && instr_req && n == w) opcode = op;
      @(posedge clk); #1;
      if (r) begin
        if (n == w) done = 1'b1;
        n++;
      end
    end
    if (!done) chk("handshake_timeout", 64'(done), 64'd1);
  endtask

  task automatic run_instr(input logic [6:0] op, input int fw, input int dw);
    q.push_back(model(op, fw, dw));
    hs(1'b0, fw, op);
    if (op == 7'b0000011 || op == 7'b0100011) hs(1'b1, dw, op);
  endtask

  task automatic drain();
    instr_ack = 1'b0; data_ack = 1'b0;
    for (int g = 0; g < 40 && q.size() > 0; g++) begin @(posedge clk); #1; end
    chk("queue_drained", 64'(q.size()), 64'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; instr_ack = 1'b0; data_ack = 1'b0;
    q.delete();
    #1;
    chk("reset_outputs", {state_o, illegal, ir_en, pc_en, reg_we, instr_req, data_req, data_we}, 64'd0);
    chk("reset_counters", {cycle_cnt, instret_cnt}, 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("release_instr_req", 64'(instr_req), 64'd1);
  endtask

  logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
`ifdef CPU_SEQ_PERF_CNT_EN
  logic [31:0] c0;
`endif

  initial begin
    do_reset();

    // Directed: zero-wait ADD, LW with 3-cycle data wait, SW, BEQ, JAL.
    run_instr(7'b0110011, 0, 0);
    run_instr(7'b0000011, 0, 3);
    run_instr(7'b0100011, 1, 2);
    run_instr(7'b1100011, 0, 0);
    run_instr(7'b1101111, 2, 0);

    for (int i = 0; i < 40; i++)
      run_instr(legal_ops[$urandom_range(8)], $urandom_range(3), $urandom_range(3));
    drain();

    // Ten back-to-back zero-wait branches: 3 cycles each.
    do_reset();
    for (int i = 0; i < 10; i++) run_instr(7'b1100011, 0, 0);
    instr_ack = 1'b0; data_ack = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
`ifdef CPU_SEQ_PERF_CNT_EN
    chk("instret_10_branches", 64'(instret_cnt), 64'd10);
    chk("cycles_10_branches", 64'(cycle_cnt), 64'd30);
    force dut.cyc_q = 32'hFFFF_FFFF;
    #1 release dut.cyc_q;
    chk("cycle_preload", 64'(cycle_cnt), 64'hFFFF_FFFF);
    @(posedge clk); #1;
    chk("cycle_wrap", 64'(cycle_cnt), 64'd0);
`else
    chk("instret_tied_zero", 64'(instret_cnt), 64'd0);
    chk("cycle_tied_zero", 64'(cycle_cnt), 64'd0);
`endif
    drain();

    // Illegal opcode traps and stays trapped regardless of acks.
    do_reset();
    run_instr(7'b0000000, 1, 0);
    instr_ack = 1'b0; data_ack = 1'b0;
    @(posedge clk); #1;
`ifdef CPU_SEQ_PERF_CNT_EN
    c0 = cycle_cnt;
`endif
    for (int i = 0; i < 4; i++) begin
      instr_ack = 1'b1; data_ack = 1'b1;
      @(posedge clk); #1;
      chk("trap_state", 64'(state_o), 64'd5);
      chk("trap_illegal", 64'(illegal), 64'd1);
      chk("trap_strobes", {instr_req, data_req, data_we, ir_en, pc_en, reg_we}, 64'd0);
`ifdef CPU_SEQ_PERF_CNT_EN
      chk("trap_cycle_frozen", 64'(cycle_cnt), 64'(c0));
`endif
    end
    chk("trap_retired", 64'(q.size()), 64'd0);
    rst_n = 1'b0;
    #1 chk("reset_clears_illegal", 64'(illegal), 64'd0);

    // Reset asserted while a load waits in MEM.
    mon_en = 1'b0;
    do_reset();
    hs(1'b0, 0, 7'b0000011);
    instr_ack = 1'b0; data_ack = 1'b0;
    for (int g = 0; g < 10 && !data_req; g++) begin @(posedge clk); #1; end
    repeat (2) begin @(posedge clk); #1; end
    chk("mem_wait_req", {data_req, data_we}, 64'b10);
    #2 rst_n = 1'b0;
    #1 chk("async_drop", {state_o, data_req, instr_req}, 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk("post_reset_fetch", {state_o, instr_req}, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
CPU_SEQUENCER -- requirements
Module: cpu_sequencer

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port: opcode  input  7  instruction-register opcode field; valid from DECODE onward.
REQ-004 SHALL have ports: instr_req  output  1 and instr_ack  input  1; instruction-fetch handshake.
REQ-005 SHALL have ports: data_req  output  1, data_we  output  1 and data_ack  input  1; data-memory handshake.
REQ-006 SHALL have ports: ir_en  output  1 (instruction register load), pc_en  output  1 (PC update) and reg_we  output  1 (register-file write strobe).
REQ-007 SHALL have ports: state_o  output  3 (current state code) and illegal  output  1 (sticky trap flag).
REQ-008 SHALL have ports: cycle_cnt  output  32 and instret_cnt  output  32 (performance counters).

Function
REQ-009 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5; codes 6-7 SHALL go to TRAP.
REQ-010 FETCH: instr_req=1 every cycle until instr_ack=1; in the ack cycle ir_en=1 for one cycle; next state DECODE.
REQ-011 instr_ack or data_ack SHALL be ignored unless the matching req is high in the same cycle; ack in the first req cycle SHALL complete the handshake (zero-wait).
REQ-012 DECODE: opcode classified as ALU (0110011, 0010011), LOAD (0000011), STORE (0100011), BRANCH (1100011), JUMP (1101111, 1100111) or UPPER (0110111, 0010111); any other value SHALL go to TRAP, else EXEC.
REQ-013 EXEC: LOAD/STORE go to MEM; BRANCH asserts pc_en for one cycle and goes to FETCH; all other classes go to WB.
REQ-014 MEM: data_req=1 until data_ack; data_we=1 throughout for STORE, 0 for LOAD; on ack LOAD goes to WB, STORE asserts pc_en for one cycle and goes to FETCH.
REQ-015 WB: reg_we=1 and pc_en=1 for exactly one cycle; next state FETCH.
REQ-016 TRAP: illegal=1; all strobes and reqs SHALL be 0; the FSM SHALL stay in TRAP until reset.
REQ-017 Every other output SHALL be 0 in states where this section does not drive it; all outputs SHALL be decoded from registered state (no combinational ack-to-req path except ir_en/pc_en qualified by ack).
REQ-018 Latency: ALU instruction with zero-wait fetch = 4 cycles (FETCH, DECODE, EXEC, WB); LOAD = 5; STORE = 4; BRANCH = 3.
REQ-019 Retirement SHALL be defined as the cycle where pc_en=1.

Reset
REQ-020 While rst_n=0, state SHALL be FETCH; illegal, ir_en, pc_en, reg_we, instr_req, data_req, data_we = 0; counters = 0.
REQ-021 Reset asserted mid-handshake SHALL drop the req immediately; after deassertion the first cycle SHALL present instr_req=1.

Configuration
REQ-022 Macro CPU_SEQ_PERF_CNT_EN defined: cycle_cnt SHALL increment every cycle out of reset and instret_cnt SHALL increment on each pc_en; both wrap 0xFFFFFFFF->0 and freeze in TRAP.
REQ-023 Macro undefined: the counter ports SHALL remain and be tied to 0; no counter flops SHALL be inferred.

Structure
REQ-024 Package cpu_pkg SHALL hold the state enum (3-bit), the opcode-class enum and the opcode localparams.
REQ-025 Sub-module cpu_opclass SHALL perform the combinational opcode-to-class mapping, with an illegal output; the FSM SHALL remain in cpu_sequencer.

Verification
REQ-026 ADD (opcode 0110011), instr_ack high in the first req cycle -> state sequence 0,1,2,4,0; reg_we=pc_en=1 only in cycle 4; ir_en=1 only in cycle 1.
REQ-027 LW (0000011) with data_ack delayed 3 cycles -> data_req high 4 cycles with data_we=0; WB follows; total 8 cycles.
REQ-028 SW (0100011) -> data_we=1 with data_req; pc_en pulse on ack; reg_we never asserted.
REQ-029 Opcode 0000000 in DECODE -> TRAP, illegal=1 sticky; a later instr_ack=1 produces no req or strobe; rst_n low clears illegal.
REQ-030 rst_n pulsed low during MEM wait -> data_req drops asynchronously; FETCH with instr_req=1 on the first cycle after release.
REQ-031 With CPU_SEQ_PERF_CNT_EN, 10 back-to-back zero-wait BEQ (1100011) -> instret_cnt=10, cycle_cnt=30; with cycle_cnt preloaded to 0xFFFFFFFF by force -> wraps to 0.
